// File: rtl/adc_ascii_framer.sv
// Captures one 12-bit ADC sample, converts it to four decimal ASCII digits with a
// sequential double-dabble, and streams the frame through a dv/ack/done byte handshake.
module adc_ascii_framer #(
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sample_dv,
  input  logic [11:0] i_sample,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_dv,
  input  logic        i_tx_ack,
  input  logic        i_tx_done,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_overrun
);

  // Handshake: o_tx_dv rises with a stable o_tx_byte and holds until i_tx_ack is sampled
  // high; i_tx_done then marks the end of that byte (it may arrive on the ack edge itself).
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONVERT   = 3'd1,
    LOAD      = 3'd2,
    SEND      = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  localparam logic [2:0] LAST_IDX = SEND_CRLF ? 3'd5 : 3'd3;

  state_t      state, state_n;
  logic [11:0] bin_q, bin_n;
  logic [15:0] bcd_q, bcd_n;
  logic [15:0] bcd_adj;
  logic [3:0]  cnt_q, cnt_n;
  logic [2:0]  idx_q, idx_n;
  logic [7:0]  byte_q, byte_n;
  logic        dv_q, dv_n;
  logic        busy_q, busy_n;
  logic        fdone_q, fdone_n;
  logic        ovr_q, ovr_n;
  logic        byte_done;
  logic [7:0]  load_byte;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      bin_q   <= 12'd0;
      bcd_q   <= 16'd0;
      cnt_q   <= 4'd0;
      idx_q   <= 3'd0;
      byte_q  <= 8'h00;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_n;
      bin_q   <= bin_n;
      bcd_q   <= bcd_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      byte_q  <= byte_n;
      dv_q    <= dv_n;
      busy_q  <= busy_n;
      fdone_q <= fdone_n;
      ovr_q   <= ovr_n;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    case (idx_q)
      3'd0:    load_byte = 8'h30 + {4'h0, bcd_q[15:12]};
      3'd1:    load_byte = 8'h30 + {4'h0, bcd_q[11:8]};
      3'd2:    load_byte = 8'h30 + {4'h0, bcd_q[7:4]};
      3'd3:    load_byte = 8'h30 + {4'h0, bcd_q[3:0]};
      3'd4:    load_byte = 8'h0D;
      default: load_byte = 8'h0A;
    endcase
  end

  always_comb begin
    state_n   = state;
    bin_n     = bin_q;
    bcd_n     = bcd_q;
    cnt_n     = cnt_q;
    idx_n     = idx_q;
    byte_n    = byte_q;
    dv_n      = dv_q;
    busy_n    = busy_q;
    fdone_n   = 1'b0;
    byte_done = 1'b0;
    // The cycle showing o_frame_done is still part of the old frame, so a sample there is dropped.
    ovr_n     = i_sample_dv && (state != IDLE || fdone_q);

    case (state)
      IDLE: begin
        if (i_sample_dv && !fdone_q) begin
          bin_n   = i_sample;
          bcd_n   = 16'd0;
          cnt_n   = 4'd0;
          idx_n   = 3'd0;
          busy_n  = 1'b1;
          state_n = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_n, bin_n} = {bcd_adj[14:0], bin_q, 1'b0};
        cnt_n = cnt_q + 4'd1;
        if (cnt_q == 4'd11) state_n = LOAD;
      end
      LOAD: begin
        byte_n  = load_byte;
        dv_n    = 1'b1;
        state_n = SEND;
      end
      SEND: begin
        if (i_tx_ack) begin
          dv_n      = 1'b0;
          byte_done = i_tx_done;
          state_n   = WAIT_DONE;
        end
      end
      WAIT_DONE: byte_done = i_tx_done;
      default:   state_n = IDLE;
    endcase

    if (byte_done) begin
      idx_n = idx_q + 3'd1;
      if (idx_q == LAST_IDX) begin
        fdone_n = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end else begin
        state_n = LOAD;
      end
    end
  end

  assign o_tx_byte    = byte_q;
  assign o_tx_dv      = dv_q;
  assign o_busy       = busy_q;
  assign o_frame_done = fdone_q;
  assign o_overrun    = ovr_q;

endmodule
